// File: rtl/fp_div_unit.sv
// ---------------------------------------------------------------------------
// fp_div_unit
// Iterative IEEE-754 binary32 divider for fdiv.s. The dividend comes from
// frs1 and the divisor from frs2. The quotient feeds the fourth input of the
// FP destination-write select mux. The core stalls while busy is high.
// Rounding is always round-to-nearest-even, and subnormal inputs are treated
// as signed zero. Results that would be subnormal are flushed to zero.
//
// Ports
//   clk    : clock; all state updates on the rising edge
//   rst    : synchronous active-high reset; abandons any divide in flight
//   start  : request; sampled only in IDLE
//   op_a   : dividend, captured on the accepting edge
//   op_b   : divisor, captured on the accepting edge
//   busy   : high in every state except IDLE
//   done   : one-cycle pulse; result and flags are valid
//   result : quotient; held until the next accepted start
//   flags  : {NV,DZ,OF,UF,NX}; held together with result
// ---------------------------------------------------------------------------
module fp_div_unit #(
   parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  flags
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_ROUND,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [4:0]  r_count;
   logic        r_sign;
   logic [9:0]  r_exp;
   logic [23:0] r_divisor;
   logic [25:0] r_rem;
   logic [26:0] r_q;
   logic [31:0] r_result;
   logic [4:0]  r_flags;

   // Operand field decode
   logic [7:0]  w_expA, w_expB;
   logic [22:0] w_fracA, w_fracB;
   logic        w_aZero, w_bZero, w_aInf, w_bInf;
   logic        w_aNan, w_bNan, w_aSnan, w_bSnan;
   logic        w_sign;

   assign w_expA  = op_a[30:23];
   assign w_expB  = op_b[30:23];
   assign w_fracA = op_a[22:0];
   assign w_fracB = op_b[22:0];
   assign w_sign  = op_a[31] ^ op_b[31];

   // A zero exponent covers both true zeros and subnormals, which are flushed
   assign w_aZero = (w_expA == 8'd0);
   assign w_bZero = (w_expB == 8'd0);
   assign w_aInf  = (w_expA == 8'hFF) && (w_fracA == 23'd0);
   assign w_bInf  = (w_expB == 8'hFF) && (w_fracB == 23'd0);
   assign w_aNan  = (w_expA == 8'hFF) && (w_fracA != 23'd0);
   assign w_bNan  = (w_expB == 8'hFF) && (w_fracB != 23'd0);
   assign w_aSnan = w_aNan && !w_fracA[22];
   assign w_bSnan = w_bNan && !w_fracB[22];

   // Special-operand classification. The checks are ordered so that NaN
   // inputs win over everything else, and invalid forms win over infinities
   // and divide-by-zero.
   logic        w_special;
   logic [31:0] w_specResult;
   logic [4:0]  w_specFlags;

   always_comb begin
      w_special    = 1'b1;
      w_specResult = 32'h0;
      w_specFlags  = 5'h0;
      if (w_aNan || w_bNan) begin
         w_specResult = CANON_NAN;
         w_specFlags  = {(w_aSnan || w_bSnan), 4'b0000};
      end else if ((w_aZero && w_bZero) || (w_aInf && w_bInf)) begin
         w_specResult = CANON_NAN;
         w_specFlags  = 5'b10000;
      end else if (w_aInf) begin
         w_specResult = {w_sign, 8'hFF, 23'd0};
      end else if (w_bZero) begin
         w_specResult = {w_sign, 8'hFF, 23'd0};
         w_specFlags  = 5'b01000;
      end else if (w_aZero || w_bInf) begin
         w_specResult = {w_sign, 31'd0};
      end else begin
         w_special = 1'b0;
      end
   end

   // One restoring-division step: subtract the divisor when it fits, then
   // shift the partial remainder left for the next quotient bit.
   logic [26:0] w_trial;
   logic        w_fits;
   logic [25:0] w_remSel;

   assign w_trial  = {1'b0, r_rem} - {3'b000, r_divisor};
   assign w_fits   = !w_trial[26];
   assign w_remSel = w_fits ? w_trial[25:0] : r_rem;

   // Normalise, round to nearest even and range-check the finished quotient.
   // The quotient lies in (0.5, 2), so the only normalisation needed is a
   // one-bit shift when the top bit is clear.
   logic [23:0]        w_mant;
   logic               w_guard;
   logic               w_sticky;
   logic [9:0]         w_expAdj;
   logic               w_roundUp;
   logic [24:0]        w_mantSum;
   logic signed [9:0]  w_expFinal;
   logic [22:0]        w_fracOut;
   logic               w_inexact;
   logic [31:0]        w_roundResult;
   logic [4:0]         w_roundFlags;

   always_comb begin
      w_mant        = r_q[26:3];
      w_guard       = r_q[2];
      w_sticky      = (r_rem != 26'd0) || (r_q[1:0] != 2'b00);
      w_expAdj      = r_exp;
      w_roundResult = 32'h0;
      w_roundFlags  = 5'h0;
      if (!r_q[26]) begin
         w_mant   = r_q[25:2];
         w_guard  = r_q[1];
         w_sticky = (r_rem != 26'd0) || r_q[0];
         w_expAdj = r_exp - 10'd1;
      end
      w_roundUp  = w_guard && (w_sticky || w_mant[0]);
      w_mantSum  = {1'b0, w_mant} + {24'd0, w_roundUp};
      w_expFinal = $signed(w_expAdj + {9'd0, w_mantSum[24]});
      w_fracOut  = w_mantSum[24] ? w_mantSum[23:1] : w_mantSum[22:0];
      w_inexact  = w_guard || w_sticky;
      if (w_expFinal >= 10'sd255) begin
         w_roundResult = {r_sign, 8'hFF, 23'd0};
         w_roundFlags  = 5'b00101;
      end else if (w_expFinal <= 10'sd0) begin
         w_roundResult = {r_sign, 31'd0};
         w_roundFlags  = 5'b00011;
      end else begin
         w_roundResult = {r_sign, w_expFinal[7:0], w_fracOut};
         w_roundFlags  = {4'b0000, w_inexact};
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Special operands skip the divide and go straight to
   // DONE; start is ignored everywhere except IDLE.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (start) w_nextState = w_special ? S_DONE : S_DIV;
         S_DIV:   if (r_count == 5'd26) w_nextState = S_ROUND;
         S_ROUND: w_nextState = S_DONE;
         S_DONE:  w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Datapath: capture operands on acceptance, iterate the divider, and
   // register the final result. result/flags only change on reset, on a
   // special-operand acceptance or at the end of ROUND.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count   <= 5'd0;
         r_sign    <= 1'b0;
         r_exp     <= 10'd0;
         r_divisor <= 24'd0;
         r_rem     <= 26'd0;
         r_q       <= 27'd0;
         r_result  <= 32'h0;
         r_flags   <= 5'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_count   <= 5'd0;
                  r_sign    <= w_sign;
                  r_exp     <= {2'b00, w_expA} - {2'b00, w_expB} + 10'd127;
                  r_divisor <= {1'b1, w_fracB};
                  r_rem     <= {3'b001, w_fracA};
                  r_q       <= 27'd0;
                  if (w_special) begin
                     r_result <= w_specResult;
                     r_flags  <= w_specFlags;
                  end
               end
            end
            S_DIV: begin
               r_count <= r_count + 5'd1;
               r_q     <= {r_q[25:0], w_fits};
               r_rem   <= w_remSel << 1;
            end
            S_ROUND: begin
               r_result <= w_roundResult;
               r_flags  <= w_roundFlags;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);
   assign result = r_result;
   assign flags  = r_flags;

endmodule
